// File: rtl/ctrl_pkg.sv
// ctrl_pkg: state encoding, datapath select codes and cmd constants for the multicycle controller.
package ctrl_pkg;
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, TRAP
    } state_t;
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;
    localparam logic [1:0] SRCA_RN = 2'b00;
    localparam logic [1:0] SRCA_PC = 2'b01;
    localparam logic [1:0] SRCA_ALUOUT = 2'b10;
    localparam logic [1:0] SRCB_RM = 2'b00;
    localparam logic [1:0] SRCB_IMM = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;
endpackage

// File: rtl/alu_dec.sv
// alu_dec: maps cmd and S bit to ALU operation and flag-write request during execute states.
`include "codes.sv"
module alu_dec
    import ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [3:0] cmd,
    input  logic       s,
    output logic [1:0] alu_control,
    output logic [3:0] flag_w
);
    logic exec, arith;
    assign exec = state == EXECR || state == EXECI;
    assign alu_control = !exec ? ALU_ADD :
                         cmd == CMD_SUB ? ALU_SUB :
                         cmd == CMD_AND ? ALU_AND :
                         cmd == CMD_ORR ? ALU_ORR : ALU_ADD;
    // carry/overflow are only meaningful for arithmetic ops
    assign arith = alu_control == ALU_ADD || alu_control == ALU_SUB;
    always_comb begin
        flag_w = '0;
        flag_w[`NEG] = exec & s;
        flag_w[`ZER] = exec & s;
        flag_w[`CAR] = exec & s & arith;
        flag_w[`OVR] = exec & s & arith;
    end
endmodule

// File: rtl/codes.sv
// codes: bit positions of the N/Z/C/V flags inside the FlagW vector.
`ifndef CODES_SV
`define CODES_SV
`define NEG 3
`define ZER 2
`define CAR 1
`define OVR 0
`endif

// File: rtl/main_fsm.sv
// main_fsm: Moore sequencer for the multicycle ARM datapath.
// MAIN_FSM_UNDEF_TRAP_EN: Op=11 enters a TRAP state flagged on the undef port.
module main_fsm
    import ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       NextPC,
    output logic [1:0] ALUControl,
    output logic [3:0] FlagW,
    output logic       PCS,
    output logic       RegW,
    output logic       MemW
`ifdef MAIN_FSM_UNDEF_TRAP_EN
    ,
    output logic       undef
`endif
);
`ifdef MAIN_FSM_UNDEF_TRAP_EN
    localparam state_t UNDEF_NEXT = TRAP;
`else
    localparam state_t UNDEF_NEXT = FETCH;
`endif
    logic [STATE_W-1:0] state_q, state_d;
    state_t state, next;
    logic branch;
    assign state = state_t'(state_q[3:0]);
    assign state_d = STATE_W'(next);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= STATE_W'(FETCH);
        else state_q <= state_d;
    end
    always_comb begin
        next = FETCH;
        case (state)
            FETCH:        next = DECODE;
            DECODE:       next = Op == 2'b01 ? MEMADR :
                                 Op == 2'b00 ? (Funct[5] ? EXECI : EXECR) :
                                 Op == 2'b10 ? BRANCH : UNDEF_NEXT;
            MEMADR:       next = Funct[0] ? MEMRD : MEMWR;
            MEMRD:        next = MEMWB;
            EXECR, EXECI: next = ALUWB;
`ifdef MAIN_FSM_UNDEF_TRAP_EN
            TRAP:         next = TRAP;
`endif
            default:      next = FETCH;
        endcase
    end
    always_comb begin
        IRWrite = 1'b0;
        AdrSrc = 1'b0;
        ALUSrcA = SRCA_RN;
        ALUSrcB = SRCB_RM;
        ResultSrc = RES_ALUOUT;
        NextPC = 1'b0;
        RegW = 1'b0;
        MemW = 1'b0;
        branch = 1'b0;
        case (state)
            FETCH: begin
                IRWrite = 1'b1;
                ALUSrcA = SRCA_PC;
                ALUSrcB = SRCB_FOUR;
                ResultSrc = RES_ALURES;
                NextPC = 1'b1;
            end
            DECODE: begin
                ALUSrcA = SRCA_PC;
                ALUSrcB = SRCB_FOUR;
                ResultSrc = RES_ALURES;
            end
            MEMADR: ALUSrcB = SRCB_IMM;
            MEMRD:  AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = RES_DATA;
                RegW = 1'b1;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                MemW = 1'b1;
            end
            EXECI:  ALUSrcB = SRCB_IMM;
            ALUWB:  RegW = 1'b1;
            BRANCH: begin
                ALUSrcA = SRCA_ALUOUT;
                ALUSrcB = SRCB_IMM;
                ResultSrc = RES_ALURES;
                branch = 1'b1;
            end
            default: ;
        endcase
    end
    assign PCS = branch | (RegW & (Rd == 4'hF));
`ifdef MAIN_FSM_UNDEF_TRAP_EN
    assign undef = state == TRAP;
`endif
    alu_dec u_alu_dec (
        .state      (state),
        .cmd        (Funct[4:1]),
        .s          (Funct[0]),
        .alu_control(ALUControl),
        .flag_w     (FlagW)
    );
endmodule

// File: tb/tb_main_fsm.sv
// tb_main_fsm: randomized scoreboard bench; expected per-cycle outputs come from an instruction-level model.
module tb_main_fsm;
    typedef struct packed {
        logic       irw;
        logic       adr;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [1:0] res;
        logic       npc;
        logic [1:0] aluc;
        logic [3:0] flagw;
        logic       pcs;
        logic       regw;
        logic       memw;
        logic       undef;
    } out_t;
    typedef struct {
        out_t o;
        int   ph;
    } exp_t;
    localparam int P_FETCH = 0, P_DEC = 1, P_ADR = 2, P_RD = 3, P_WB = 4, P_WR = 5;
    localparam int P_EXR = 6, P_EXI = 7, P_ALUWB = 8, P_BR = 9, P_TRAP = 10;

    logic clk = 1'b0, reset = 1'b1;
    logic [1:0] Op = '0;
    logic [5:0] Funct = '0;
    logic [3:0] Rd = '0;
    logic IRWrite, AdrSrc, NextPC, PCS, RegW, MemW, und_w;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ALUControl;
    logic [3:0] FlagW;
    exp_t q[$];
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    main_fsm dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .NextPC(NextPC), .ALUControl(ALUControl), .FlagW(FlagW),
        .PCS(PCS), .RegW(RegW), .MemW(MemW)
`ifdef MAIN_FSM_UNDEF_TRAP_EN
        , .undef(und_w)
`endif
    );
`ifndef MAIN_FSM_UNDEF_TRAP_EN
    assign und_w = 1'b0;
`endif

    function automatic out_t model(input int ph, input logic [5:0] f, input logic [3:0] rd);
        out_t o = '0;
        logic br = 1'b0;
        logic arith;
        case (ph)
            P_FETCH: begin o.irw = 1; o.srca = 2'b01; o.srcb = 2'b10; o.res = 2'b10; o.npc = 1; end
            P_DEC:   begin o.srca = 2'b01; o.srcb = 2'b10; o.res = 2'b10; end
            P_ADR:   o.srcb = 2'b01;
            P_RD:    o.adr = 1;
            P_WB:    begin o.res = 2'b01; o.regw = 1; end
            P_WR:    begin o.adr = 1; o.memw = 1; end
            P_EXR, P_EXI: begin
                o.srcb = ph == P_EXI ? 2'b01 : 2'b00;
                case (f[4:1])
                    4'b0010: o.aluc = 2'b01;
                    4'b0000: o.aluc = 2'b10;
                    4'b1100: o.aluc = 2'b11;
                    default: o.aluc = 2'b00;
                endcase
                arith = o.aluc == 2'b00 || o.aluc == 2'b01;
                if (f[0]) o.flagw = {1'b1, 1'b1, arith, arith};
            end
            P_ALUWB: o.regw = 1;
            P_BR:    begin o.srca = 2'b10; o.srcb = 2'b01; o.res = 2'b10; br = 1; end
            P_TRAP:  o.undef = 1;
            default: ;
        endcase
        o.pcs = br | (o.regw && rd == 4'd15);
        return o;
    endfunction

    task automatic push(input int ph, input logic [5:0] f, input logic [3:0] rd);
        exp_t e;
        e.o = model(ph, f, rd);
        e.ph = ph;
        q.push_back(e);
    endtask

    // entered and left one time unit after a rising edge
    task automatic run_instr(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd, input int stop_after);
        int seq[$];
        seq = {P_FETCH, P_DEC};
        case (op)
            2'b01: seq = f[0] ? {seq, P_ADR, P_RD, P_WB} : {seq, P_ADR, P_WR};
            2'b00: seq = {seq, f[5] ? P_EXI : P_EXR, P_ALUWB};
            2'b10: seq = {seq, P_BR};
            default: begin
`ifdef MAIN_FSM_UNDEF_TRAP_EN
                for (int i = 0; i < 12; i++) seq.push_back(P_TRAP);
`endif
            end
        endcase
        while (stop_after > 0 && seq.size() > stop_after) void'(seq.pop_back());
        Op = op;
        Funct = f;
        Rd = rd;
        foreach (seq[i]) push(seq[i], f, rd);
        repeat (seq.size()) @(posedge clk);
        #1;
    endtask

    task automatic reset_cycles(input int n);
        for (int i = 0; i < n; i++) push(P_FETCH, Funct, Rd);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        out_t a;
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                a = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, ALUControl,
                     FlagW, PCS, RegW, MemW, und_w};
                n_cmp++;
                if (a !== e.o) begin
                    n_bad++;
                    $display("FAIL phase%0d t=%0t: got %b need %b", e.ph, $time, a, e.o);
                end
            end
        end
    end

    initial begin
        logic [1:0] op;
        @(posedge clk);
        #1;
        reset_cycles(2);
        reset = 0;
        run_instr(2'b01, 6'b011001, 4'd2, 0);
        run_instr(2'b01, 6'b011000, 4'd2, 0);
        run_instr(2'b00, 6'b000101, 4'd3, 0);
        run_instr(2'b00, 6'b100001, 4'd15, 0);
        run_instr(2'b10, 6'b100000, 4'd0, 0);
`ifndef MAIN_FSM_UNDEF_TRAP_EN
        run_instr(2'b11, 6'b000000, 4'd0, 0);
`endif
        run_instr(2'b01, 6'b011001, 4'd5, 3);
        reset = 1;
        reset_cycles(3);
        reset = 0;
        for (int i = 0; i < 150; i++) begin
            op = 2'($urandom_range(0, 3));
`ifdef MAIN_FSM_UNDEF_TRAP_EN
            if (op == 2'b11) op = 2'b00;
`endif
            run_instr(op, 6'($urandom), $urandom_range(0, 3) == 0 ? 4'd15 : 4'($urandom), 0);
        end
`ifdef MAIN_FSM_UNDEF_TRAP_EN
        run_instr(2'b11, 6'b000000, 4'd0, 0);
        reset = 1;
        reset_cycles(2);
        reset = 0;
        run_instr(2'b10, 6'b000000, 4'd0, 0);
`endif
        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected cycles left, need 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/main_fsm.md
Name: main_fsm

Overview:
- Multicycle control sequencer for the ARM datapath; sits directly upstream of the conditional-write stage.
- Decodes Op/Funct/Rd from the instruction register and walks a per-instruction state sequence.
- Each cycle it produces:
  - datapath mux/enable controls;
  - the unconditioned PCS, RegW, MemW and FlagW requests, which the downstream condition stage gates with CondEx.

Parameters:
- STATE_W, 4, width of the state encoding; must hold all states (min 4).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; forces FETCH
- Op  input  2  Instr[27:26]
- Funct  input  6  Instr[25:20]; [5]=I, [4:1]=cmd, [0]=S/L
- Rd  input  4  Instr[15:12]
- IRWrite  output  1  load instruction register
- AdrSrc  output  1  memory address select: 0=PC, 1=ALUOut
- ALUSrcA  output  2  00=Rn, 01=PC, 10=ALUOut
- ALUSrcB  output  2  00=Rm/shifted, 01=ExtImm, 10=const 4
- ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult
- NextPC  output  1  unconditional PC write (fetch increment)
- ALUControl  output  2  00=ADD, 01=SUB, 10=AND, 11=ORR
- FlagW  output  4  flag-write request, indexed by `NEG/`ZER/`CAR/`OVR from codes.sv
- PCS  output  1  PC-source request: Branch or (RegW & Rd==15)
- RegW  output  1  register write request
- MemW  output  1  memory write request

Behaviour:
- Moore FSM; every output is a function of the registered state plus Funct/Rd. No combinational path from Op to outputs.
- States and transitions:
  - FETCH -> DECODE.
  - DECODE:
    - Op=01 -> MEMADR
    - Op=00 & Funct[5]=0 -> EXECR
    - Op=00 & Funct[5]=1 -> EXECI
    - Op=10 -> BRANCH
    - Op=11 -> FETCH
  - MEMADR: Funct[0]=1 -> MEMRD, else -> MEMWR.
  - MEMRD -> MEMWB.
  - MEMWB, MEMWR, ALUWB, BRANCH -> FETCH.
  - EXECR, EXECI -> ALUWB.
  - Illegal encodings -> FETCH.
- Outputs per state (unlisted outputs are 0):
  - FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, NextPC=1, ALUControl=ADD.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ALUControl=ADD (PC+8 precompute).
  - MEMADR: ALUSrcA=00, ALUSrcB=01, ALUControl=ADD.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, MemW=1.
  - EXECR: ALUSrcB=00. EXECI: ALUSrcB=01. In both, ALUControl comes from cmd:
    - 0100 -> ADD
    - 0010 -> SUB
    - 0000 -> AND
    - 1100 -> ORR
    - other -> ADD
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, ALUControl=ADD, Branch internal=1.
- FlagW, asserted only in EXECR/EXECI with Funct[0]=1:
  - `NEG and `ZER set.
  - `CAR and `OVR set only when ALUControl is ADD or SUB.
- PCS = Branch | (RegW & Rd==4'hF). Combinational from state and Rd.
- Reset:
  - Asynchronous assert puts state in FETCH immediately, so outputs take FETCH values while reset is high, including NextPC=1.
  - Reset mid-instruction abandons the sequence; no RegW or MemW pulse is emitted.
- Latency per instruction class:
  - LDR: 5 cycles
  - STR: 4 cycles
  - DP: 4 cycles
  - B: 3 cycles
  - undefined: 2 cycles

Optional Feature:
- Macro: MAIN_FSM_UNDEF_TRAP_EN
- When defined:
  - DECODE with Op=11 enters TRAP, which holds forever with all outputs 0 until reset.
  - An extra output port undef (1 bit) is 1 in TRAP.
- When not defined: Op=11 returns to FETCH (executes as a NOP); no TRAP state and no undef port.

Decomposition:
- Package ctrl_pkg holds:
  - state enum typedef (FETCH..BRANCH, TRAP);
  - ALUControl, ALUSrcA/B and ResultSrc localparams;
  - cmd code constants.
- Flag-index macros stay in codes.sv.
- One sub-module, alu_dec: combinational cmd/S/state -> ALUControl and FlagW. All sequencing stays in main_fsm.

Test Plan:
- Reset held 3 cycles mid-MEMRD, then released -> state FETCH, IRWrite=1, NextPC=1, RegW=MemW=0 throughout reset.
- LDR (Op=01, Funct=011001) -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; AdrSrc=1 in MEMRD; RegW=1 and ResultSrc=01 only in cycle 5.
- STR (Op=01, Funct=011000) -> MemW=1 for exactly one cycle in cycle 4; RegW never 1.
- SUBS reg (Op=00, Funct=000101, Rd=3) -> EXECR: ALUControl=01, FlagW=4'b1111; ALUWB: RegW=1, PCS=0.
- ANDS imm with Rd=15 (Op=00, Funct=100001) -> FlagW has only `NEG,`ZER set; ALUWB: RegW=1, PCS=1.
- Branch (Op=10) -> BRANCH in cycle 3: PCS=1, ALUSrcA=10, ALUSrcB=01.
- Op=11 -> without macro, FETCH follows DECODE; with MAIN_FSM_UNDEF_TRAP_EN, undef=1 and the FSM holds for 10+ cycles.
